// File: rtl/alu_defs.sv
// Shared definitions for the ALU sequencer: FSM state codes and the ALU opcode map.
package alu_defs;

    localparam int NB_STATE = 3;

    typedef enum logic [NB_STATE-1:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Opcode values understood by the downstream ALU (funct-style encoding).
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/btn_edge.sv
// Two-flop rising-edge detector for a level push-button.
// History resets to 1 so a button already held when reset drops never produces an edge.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_edge
);

    logic r_q1;
    logic r_q2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q1 <= 1'b1;
            r_q2 <= 1'b1;
        end else begin
            r_q1 <= i_btn;
            r_q2 <= r_q1;
        end
    end

    assign o_edge = r_q1 & ~r_q2;

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads A, B and opcode from the switch bus in fixed order, waits ALU_LATENCY cycles,
// then captures the ALU result and pulses o_valid.
module alu_op_sequencer
    import alu_defs::*;
#(
    parameter int NB_DATA     = 6,
    parameter int NB_OP       = 6,
    parameter int ALU_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NB_DATA-1:0] i_sw,
    input  logic               i_btn_a,
    input  logic               i_btn_b,
    input  logic               i_btn_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_A,
    output logic [NB_DATA-1:0] o_B,
    output logic [NB_OP-1:0]   o_OP,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_seq_err,
    output logic [2:0]         o_state
);

    localparam int                NB_CNT   = $clog2(ALU_LATENCY + 1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(ALU_LATENCY - 1);

    // Bit order: [0]=A, [1]=B, [2]=OP
    logic [2:0]        w_edge;
    logic              w_exp_edge;
    state_t            r_state;
    logic [NB_CNT-1:0] r_cnt;

    btn_edge u_edge [2:0] (
        .clock  (clock),
        .reset  (reset),
        .i_btn  ({i_btn_op, i_btn_b, i_btn_a}),
        .o_edge (w_edge)
    );

    // The edge this state is waiting for; EXEC waits for none, so any edge there is an error.
    always_comb begin
        w_exp_edge = 1'b0;
        case (r_state)
            ST_WAIT_A, ST_DONE: w_exp_edge = w_edge[0];
            ST_WAIT_B:          w_exp_edge = w_edge[1];
            ST_WAIT_OP:         w_exp_edge = w_edge[2];
            default:            w_exp_edge = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_WAIT_A;
            r_cnt     <= '0;
            o_A       <= '0;
            o_B       <= '0;
            o_OP      <= '0;
            o_result  <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_seq_err <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_seq_err <= (|w_edge) & ~w_exp_edge;
            case (r_state)
                ST_WAIT_A, ST_DONE: begin
                    if (w_edge[0]) begin
                        o_A     <= i_sw;
                        r_state <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (w_edge[1]) begin
                        o_B     <= i_sw;
                        r_state <= ST_WAIT_OP;
                    end
                end
                ST_WAIT_OP: begin
                    if (w_edge[2]) begin
                        o_OP    <= i_sw[NB_OP-1:0];
                        r_cnt   <= '0;
                        o_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == CNT_LAST) begin
                        o_result <= i_alu_result;
                        o_valid  <= 1'b1;
                        o_busy   <= 1'b0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_WAIT_A;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: two sequencers (latency 1 and 3) each driving a behavioural ALU.
module tb_alu_op_sequencer;
    import alu_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [2];
    logic [5:0] sw    [2];
    logic       ba    [2];
    logic       bb    [2];
    logic       bo    [2];
    logic [5:0] alu_r [2];
    logic [5:0] oA    [2];
    logic [5:0] oB    [2];
    logic [5:0] oOP   [2];
    logic [5:0] oRes  [2];
    logic       oV    [2];
    logic       oBusy [2];
    logic       oErr  [2];
    logic [2:0] oSt   [2];

    function automatic logic [5:0] alu_f(input logic [5:0] a, input logic [5:0] b, input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return $signed(a) >>> b;
            OP_SRL:  return a >> b;
            default: return 6'd0;
        endcase
    endfunction

    assign alu_r[0] = alu_f(oA[0], oB[0], oOP[0]);
    assign alu_r[1] = alu_f(oA[1], oB[1], oOP[1]);

    alu_op_sequencer #(.NB_DATA(6), .NB_OP(6), .ALU_LATENCY(1)) dut0 (
        .clock(clk), .reset(rst[0]), .i_sw(sw[0]), .i_btn_a(ba[0]), .i_btn_b(bb[0]),
        .i_btn_op(bo[0]), .i_alu_result(alu_r[0]), .o_A(oA[0]), .o_B(oB[0]), .o_OP(oOP[0]),
        .o_result(oRes[0]), .o_valid(oV[0]), .o_busy(oBusy[0]), .o_seq_err(oErr[0]), .o_state(oSt[0])
    );

    alu_op_sequencer #(.NB_DATA(6), .NB_OP(6), .ALU_LATENCY(3)) dut1 (
        .clock(clk), .reset(rst[1]), .i_sw(sw[1]), .i_btn_a(ba[1]), .i_btn_b(bb[1]),
        .i_btn_op(bo[1]), .i_alu_result(alu_r[1]), .o_A(oA[1]), .o_B(oB[1]), .o_OP(oOP[1]),
        .o_result(oRes[1]), .o_valid(oV[1]), .o_busy(oBusy[1]), .o_seq_err(oErr[1]), .o_state(oSt[1])
    );

    typedef struct { int dut; logic [5:0] res; int cyc; } vexp_t;
    typedef struct { int dut; logic [2:0] st; } eexp_t;

    vexp_t vq[$];
    eexp_t eq[$];
    vexp_t ve;
    eexp_t ee;
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    busy_cnt [2] = '{0, 0};
    int    b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid or error pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (oBusy[d]) busy_cnt[d]++;
            if (oV[d]) begin
                if (vq.size() == 0) chk("valid_unexpected_dut", d, -1);
                else begin
                    ve = vq.pop_front();
                    chk("valid_dut", d, ve.dut);
                    chk("valid_result", int'(oRes[d]), int'(ve.res));
                    chk("valid_cycle", cyc, ve.cyc);
                end
            end
            if (oErr[d]) begin
                if (eq.size() == 0) chk("err_unexpected_dut", d, -1);
                else begin
                    ee = eq.pop_front();
                    chk("err_dut", d, ee.dut);
                    chk("err_state", int'(oSt[d]), int'(ee.st));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // m = {op,b,a}; kind 0 = no event, 1 = seq error expected (state est), 2 = valid expected (res)
    task automatic press(input int d, input logic [2:0] m, input logic [5:0] v,
                         input int kind, input logic [5:0] res, input logic [2:0] est);
        @(negedge clk);
        if (kind == 1) eq.push_back('{dut: d, st: est});
        if (kind == 2) vq.push_back('{dut: d, res: res, cyc: cyc + 2 + ((d == 0) ? 1 : 3)});
        sw[d] = v;
        {bo[d], bb[d], ba[d]} = m;
        @(negedge clk);
        {bo[d], bb[d], ba[d]} = 3'b000;
        @(negedge clk);
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        idle(2);
        rst[d] = 1'b0;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_A"}, int'(oA[d]), 0);
        chk({tag, "_B"}, int'(oB[d]), 0);
        chk({tag, "_OP"}, int'(oOP[d]), 0);
        chk({tag, "_result"}, int'(oRes[d]), 0);
        chk({tag, "_valid"}, int'(oV[d]), 0);
        chk({tag, "_busy"}, int'(oBusy[d]), 0);
        chk({tag, "_seq_err"}, int'(oErr[d]), 0);
        chk({tag, "_state"}, int'(oSt[d]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; sw[d] = '0; ba[d] = 1'b0; bb[d] = 1'b0; bo[d] = 1'b0;
        end
        idle(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idle(1);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");

        // ADD 2+3 at latency 1
        press(0, 3'b001, 6'd2, 0, 6'd0, 3'd0);
        press(0, 3'b010, 6'd3, 0, 6'd0, 3'd0);
        press(0, 3'b100, OP_ADD, 2, 6'd5, 3'd0);
        idle(2);
        chk("add_A", int'(oA[0]), 2);
        chk("add_B", int'(oB[0]), 3);
        chk("add_OP", int'(oOP[0]), 32);
        chk("add_result", int'(oRes[0]), 5);
        chk("add_state", int'(oSt[0]), 4);

        // Back-to-back from DONE: A alone changes only o_A
        press(0, 3'b001, 6'd7, 0, 6'd0, 3'd0);
        chk("b2b_state", int'(oSt[0]), 1);
        chk("b2b_A", int'(oA[0]), 7);
        chk("b2b_B_held", int'(oB[0]), 3);
        chk("b2b_OP_held", int'(oOP[0]), 32);
        chk("b2b_result_held", int'(oRes[0]), 5);
        press(0, 3'b010, 6'd7, 0, 6'd0, 3'd0);
        press(0, 3'b100, OP_AND, 2, 6'd7, 3'd0);
        idle(2);
        chk("and_result", int'(oRes[0]), 7);
        chk("and_state", int'(oSt[0]), 4);

        // Out-of-order button, then coincident A+B
        do_reset(0);
        press(0, 3'b010, 6'd9, 1, 6'd0, 3'd0);
        idle(1);
        chk("order_state", int'(oSt[0]), 0);
        chk("order_B", int'(oB[0]), 0);
        press(0, 3'b011, 6'd4, 0, 6'd0, 3'd0);
        idle(1);
        chk("coinc_state", int'(oSt[0]), 1);
        chk("coinc_A", int'(oA[0]), 4);
        chk("coinc_B", int'(oB[0]), 0);

        // Held button with changing switches: one load, value present on the action edge
        do_reset(0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sw[0] = 6'(10 + i);
            ba[0] = 1'b1;
        end
        @(negedge clk);
        ba[0] = 1'b0;
        idle(2);
        chk("held_state", int'(oSt[0]), 1);
        chk("held_A", int'(oA[0]), 11);

        // Latency 3: SUB 6-5, with a stray A press during EXEC
        press(1, 3'b001, 6'd6, 0, 6'd0, 3'd0);
        press(1, 3'b010, 6'd5, 0, 6'd0, 3'd0);
        b0 = busy_cnt[1];
        press(1, 3'b100, OP_SUB, 2, 6'd1, 3'd0);
        eq.push_back('{dut: 1, st: 3'd3});
        ba[1] = 1'b1;
        idle(1);
        ba[1] = 1'b0;
        idle(4);
        chk("lat_busy_cycles", busy_cnt[1] - b0, 3);
        chk("lat_state", int'(oSt[1]), 4);
        chk("lat_result", int'(oRes[1]), 1);
        chk("lat_A_held", int'(oA[1]), 6);

        // Reset while in EXEC: no valid, everything back to zero
        press(1, 3'b001, 6'd1, 0, 6'd0, 3'd0);
        press(1, 3'b010, 6'd1, 0, 6'd0, 3'd0);
        press(1, 3'b100, OP_ADD, 0, 6'd0, 3'd0);
        chk("rexec_busy", int'(oBusy[1]), 1);
        idle(1);
        rst[1] = 1'b1;
        idle(1);
        rst[1] = 1'b0;
        chk_zero(1, "rexec");
        idle(4);
        chk("rexec_state_after", int'(oSt[1]), 0);
        chk("rexec_result_after", int'(oRes[1]), 0);

        idle(2);
        chk("valid_queue_left", vq.size(), 0);
        chk("err_queue_left", eq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
